// File: rtl/ristretto_irq_sequencer_if.sv
// ============================================================================
// Module      : ristretto_irq_sequencer_if
// Description : Interrupt-source, TCU-handshake and claim-status bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ristretto_irq_sequencer_if #(
    parameter int NumSources = 8,
    parameter int IdWidth    = 3
);
    logic [NumSources-1:0] irq_src_i;
    logic [NumSources-1:0] irq_enable_i;
    logic [NumSources-1:0] irq_edge_i;
    logic [1:0]            tcu_trap_detected_i;
    logic [4:0]            tcu_mcause_i;
    logic                  complete_i;
    logic                  ext_intr_o;
    logic [IdWidth-1:0]    claim_id_o;
    logic                  claim_valid_o;
    logic [NumSources-1:0] pending_o;

    modport slave (
        input  irq_src_i, irq_enable_i, irq_edge_i,
        input  tcu_trap_detected_i, tcu_mcause_i, complete_i,
        output ext_intr_o, claim_id_o, claim_valid_o, pending_o
    );

    modport master (
        output irq_src_i, irq_enable_i, irq_edge_i,
        output tcu_trap_detected_i, tcu_mcause_i, complete_i,
        input  ext_intr_o, claim_id_o, claim_valid_o, pending_o
    );
endinterface

`default_nettype wire

// File: rtl/ristretto_irq_sequencer.sv
// ============================================================================
// Module      : ristretto_irq_sequencer
// Description : Fixed-priority external interrupt sequencer feeding the TCU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ristretto_irq_sequencer #(
    parameter int NumSources = 8,
    parameter int IdWidth    = 3
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    ristretto_irq_sequencer_if.slave     bus
);

    localparam logic [1:0] C_TRAP_IRQ = 2'b01;
    localparam logic [4:0] C_MEXT_INT = 5'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NumSources-1:0] r_src_q;
    logic [NumSources-1:0] r_pending;
    logic                  r_arm;
    logic [IdWidth-1:0]    r_claim_id;
    logic [IdWidth-1:0]    w_claim_id_nxt;
    logic                  r_claim_valid;
    logic                  w_claim_valid_nxt;

    logic [NumSources-1:0] w_edge;
    logic [NumSources-1:0] w_set;
    logic [NumSources-1:0] w_clr;
    logic [NumSources-1:0] w_active;
    logic [IdWidth-1:0]    w_winner;
    logic                  w_ack;

    // r_arm masks the first post-reset cycle so a line already high during
    // reset is not mistaken for a fresh rising edge.
    assign w_edge   = bus.irq_src_i & ~r_src_q & bus.irq_edge_i & {NumSources{r_arm}};
    assign w_set    = w_edge | (bus.irq_src_i & ~bus.irq_edge_i);
    assign w_active = r_pending & bus.irq_enable_i;
    assign w_ack    = (bus.tcu_trap_detected_i == C_TRAP_IRQ) &&
                      (bus.tcu_mcause_i == C_MEXT_INT);

    always_comb begin
        w_winner = '0;
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_winner = IdWidth'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_src_q       <= '0;
            r_pending     <= '0;
            r_arm         <= 1'b0;
            r_claim_id    <= '0;
            r_claim_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_src_q       <= bus.irq_src_i;
            r_pending     <= (r_pending & ~w_clr) | w_set;
            r_arm         <= 1'b1;
            r_claim_id    <= w_claim_id_nxt;
            r_claim_valid <= w_claim_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_claim_id_nxt    = r_claim_id;
        w_claim_valid_nxt = r_claim_valid;
        w_clr             = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_active) begin
                    w_state_nxt    = ST_REQ;
                    w_claim_id_nxt = w_winner;
                end
            end
            ST_REQ: begin
                // A withdrawn enable takes precedence over a same-cycle ack.
                if (!bus.irq_enable_i[r_claim_id]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack) begin
                    w_state_nxt       = ST_SERVICE;
                    w_clr[r_claim_id] = 1'b1;
                    w_claim_valid_nxt = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.complete_i) begin
                    w_state_nxt       = ST_IDLE;
                    w_claim_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_claim_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.ext_intr_o    = (r_state == ST_REQ);
    assign bus.claim_id_o    = r_claim_id;
    assign bus.claim_valid_o = r_claim_valid;
    assign bus.pending_o     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_ristretto_irq_sequencer.sv
// ============================================================================
// Module      : tb_ristretto_irq_sequencer
// Description : Scoreboarded self-checking bench for ristretto_irq_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ristretto_irq_sequencer;

    localparam int C_N  = 8;
    localparam int C_IW = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic r_prev_ext;
    logic [C_IW-1:0] exp_q [$];

    ristretto_irq_sequencer_if #(.NumSources(C_N), .IdWidth(C_IW)) u_if ();

    ristretto_irq_sequencer #(.NumSources(C_N), .IdWidth(C_IW)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        u_if.tcu_trap_detected_i = 2'b01;
        u_if.tcu_mcause_i        = 5'd11;
        tick();
        u_if.tcu_trap_detected_i = 2'b00;
        u_if.tcu_mcause_i        = 5'd0;
    endtask

    task automatic done();
        u_if.complete_i = 1'b1;
        tick();
        u_if.complete_i = 1'b0;
    endtask

    // Every request the DUT raises must match the next expected claim ID.
    always @(negedge clk) begin
        if (u_if.ext_intr_o && !r_prev_ext) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("sb_claim", 32'(u_if.claim_id_o), 32'(exp_q.pop_front()));
            end
        end
        r_prev_ext = u_if.ext_intr_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        r_prev_ext = 1'b0;
        rst        = 1'b1;
        u_if.irq_src_i           = '0;
        u_if.irq_enable_i        = 8'hFF;
        u_if.irq_edge_i          = 8'hFF;
        u_if.tcu_trap_detected_i = 2'b00;
        u_if.tcu_mcause_i        = 5'd0;
        u_if.complete_i          = 1'b0;
        tick();
        tick();
        chk("rst_ext",     32'(u_if.ext_intr_o),    32'd0);
        chk("rst_id",      32'(u_if.claim_id_o),    32'd0);
        chk("rst_valid",   32'(u_if.claim_valid_o), 32'd0);
        chk("rst_pending", 32'(u_if.pending_o),     32'd0);
        rst = 1'b0;
        tick();

        // Single edge pulse on source 3
        u_if.irq_src_i = 8'h08; exp_q.push_back(3'd3);
        tick();
        chk("s1_pending", 32'(u_if.pending_o), 32'h08);
        chk("s1_ext_early", 32'(u_if.ext_intr_o), 32'd0);
        u_if.irq_src_i = 8'h00;
        tick();
        chk("s1_ext", 32'(u_if.ext_intr_o), 32'd1);
        chk("s1_id",  32'(u_if.claim_id_o), 32'd3);
        ack();
        chk("s1_pend_clr", 32'(u_if.pending_o),     32'h00);
        chk("s1_valid",    32'(u_if.claim_valid_o), 32'd1);
        chk("s1_ext_svc",  32'(u_if.ext_intr_o),    32'd0);
        done();
        chk("s1_valid_clr", 32'(u_if.claim_valid_o), 32'd0);
        tick();
        chk("s1_idle", 32'(u_if.ext_intr_o), 32'd0);

        // Sources 5 and 1 together: 1 first, then 5
        u_if.irq_src_i = 8'h22; exp_q.push_back(3'd1); exp_q.push_back(3'd5);
        tick();
        chk("s2_pending", 32'(u_if.pending_o), 32'h22);
        u_if.irq_src_i = 8'h00;
        tick();
        chk("s2_id1", 32'(u_if.claim_id_o), 32'd1);
        ack();
        chk("s2_pend", 32'(u_if.pending_o), 32'h20);
        done();
        tick();
        chk("s2_ext5", 32'(u_if.ext_intr_o), 32'd1);
        chk("s2_id5",  32'(u_if.claim_id_o), 32'd5);
        ack();
        done();

        // Level source 2 held through complete re-pends
        u_if.irq_edge_i = 8'hFB;
        u_if.irq_src_i  = 8'h04; exp_q.push_back(3'd2); exp_q.push_back(3'd2);
        tick();
        tick();
        chk("s3_id", 32'(u_if.claim_id_o), 32'd2);
        ack();
        chk("s3_pend_set_wins", 32'(u_if.pending_o), 32'h04);
        chk("s3_valid", 32'(u_if.claim_valid_o), 32'd1);
        done();
        chk("s3_ext_idle", 32'(u_if.ext_intr_o), 32'd0);
        tick();
        chk("s3_ext_again", 32'(u_if.ext_intr_o), 32'd1);
        chk("s3_id_again",  32'(u_if.claim_id_o), 32'd2);
        u_if.irq_src_i = 8'h00;
        ack();
        done();
        chk("s3_pend_gone", 32'(u_if.pending_o), 32'h00);
        u_if.irq_edge_i = 8'hFF;

        // Withdrawal of source 4, then no re-arbitration inside REQ
        u_if.irq_src_i = 8'h10; exp_q.push_back(3'd4);
        tick();
        u_if.irq_src_i = 8'h00;
        tick();
        chk("s4_id", 32'(u_if.claim_id_o), 32'd4);
        u_if.irq_enable_i = 8'hEF;
        tick();
        chk("s4_ext_wd",  32'(u_if.ext_intr_o), 32'd0);
        chk("s4_pend_wd", 32'(u_if.pending_o),  32'h10);
        tick();
        chk("s4_masked", 32'(u_if.ext_intr_o), 32'd0);
        u_if.irq_enable_i = 8'hFF; exp_q.push_back(3'd4);
        tick();
        chk("s4_ext_re", 32'(u_if.ext_intr_o), 32'd1);
        u_if.irq_src_i = 8'h01;
        tick();
        u_if.irq_src_i = 8'h00;
        chk("s4_no_rearb", 32'(u_if.claim_id_o), 32'd4);
        chk("s4_pend_both", 32'(u_if.pending_o), 32'h11);
        exp_q.push_back(3'd0);
        ack();
        chk("s4_pend_left", 32'(u_if.pending_o), 32'h01);
        done();
        tick();
        chk("s4_id0", 32'(u_if.claim_id_o), 32'd0);
        ack();
        done();

        // Non-MEXT cause ignored; reset aborts SERVICE
        u_if.irq_src_i = 8'h40; exp_q.push_back(3'd6);
        tick();
        u_if.irq_src_i = 8'h00;
        tick();
        chk("s5_id", 32'(u_if.claim_id_o), 32'd6);
        u_if.tcu_trap_detected_i = 2'b01;
        u_if.tcu_mcause_i        = 5'd7;
        tick();
        chk("s5_stay_req",  32'(u_if.ext_intr_o),    32'd1);
        chk("s5_no_valid",  32'(u_if.claim_valid_o), 32'd0);
        chk("s5_pend_kept", 32'(u_if.pending_o),     32'h40);
        u_if.tcu_mcause_i = 5'd11;
        tick();
        u_if.tcu_trap_detected_i = 2'b00;
        u_if.tcu_mcause_i        = 5'd0;
        chk("s5_valid", 32'(u_if.claim_valid_o), 32'd1);
        u_if.irq_src_i = 8'h01;
        rst = 1'b1;
        tick();
        chk("s5_rst_ext",   32'(u_if.ext_intr_o),    32'd0);
        chk("s5_rst_id",    32'(u_if.claim_id_o),    32'd0);
        chk("s5_rst_valid", 32'(u_if.claim_valid_o), 32'd0);
        chk("s5_rst_pend",  32'(u_if.pending_o),     32'd0);

        // Edge line high across reset release must not register an event
        u_if.irq_src_i = 8'h02;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("s6_no_edge", 32'(u_if.pending_o),  32'd0);
        chk("s6_no_ext",  32'(u_if.ext_intr_o), 32'd0);
        u_if.irq_src_i = 8'h00;
        tick();
        u_if.irq_src_i = 8'h02; exp_q.push_back(3'd1);
        tick();
        chk("s6_new_edge", 32'(u_if.pending_o), 32'h02);
        u_if.irq_src_i = 8'h00;
        tick();
        chk("s6_id", 32'(u_if.claim_id_o), 32'd1);
        ack();
        done();

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ristretto_irq_sequencer.md
RISTRETTO_IRQ_SEQUENCER -- requirements
Module: ristretto_irq_sequencer

Interface
REQ-001 SHALL have parameter NumSources, default 8: number of external interrupt lines, range 2..32.
REQ-002 SHALL have parameter IdWidth, default 3: width of the claim ID; equals $clog2(NumSources).
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port irq_src_i, input, NumSources: raw interrupt lines, already synchronous to clk_i.
REQ-006 SHALL have port irq_enable_i, input, NumSources: per-source enable mask.
REQ-007 SHALL have port irq_edge_i, input, NumSources: per-source mode; 1 = rising-edge, 0 = level.
REQ-008 SHALL have port ext_intr_o, output, 1: drives tcu_ext_intr_i of the trap control unit.
REQ-009 SHALL have port tcu_trap_detected_i, input, 2: TCU trap status; 2'b01 = interrupt taken.
REQ-010 SHALL have port tcu_mcause_i, input, 5: TCU cause code; MEXT_INT = 5'd11.
REQ-011 SHALL have port complete_i, input, 1: one-cycle pulse from software/CSR logic when the handler finishes.
REQ-012 SHALL have port claim_id_o, output, IdWidth: index of the source being requested or serviced.
REQ-013 SHALL have port claim_valid_o, output, 1: high while a claimed source is in service.
REQ-014 SHALL have port pending_o, output, NumSources: pending register contents.

Function
REQ-015 SHALL register irq_src_i into src_q each cycle; edge event = irq_src_i & ~src_q & irq_edge_i.
REQ-016 SHALL set pending[i] on an edge event (edge mode) or while irq_src_i[i]=1 (level mode), regardless of irq_enable_i.
REQ-017 SHALL clear pending[i] only on a claim (REQ-021); on the same cycle, a set condition for bit i wins over the clear.
REQ-018 SHALL arbitrate by fixed priority over (pending & irq_enable_i): the lowest index wins.
REQ-019 SHALL implement FSM states IDLE, REQ, SERVICE; IDLE is the reset state.
REQ-020 SHALL, in IDLE, go to REQ and latch the winner into claim_id_o when any enabled pending bit exists; otherwise stay in IDLE.
REQ-021 SHALL, in REQ, hold ext_intr_o=1; when tcu_trap_detected_i==2'b01 and tcu_mcause_i==5'd11, go to SERVICE, clear pending[claim_id_o], and set claim_valid_o=1 from the next cycle.
REQ-022 SHALL, in REQ, return to IDLE with ext_intr_o=0 and no pending change if irq_enable_i[claim_id_o] drops (withdrawal).
REQ-023 SHALL not re-arbitrate in REQ: a higher-priority arrival does not change claim_id_o until the next IDLE pass.
REQ-024 SHALL, in SERVICE, drive ext_intr_o=0 and ignore new pending bits for arbitration; complete_i=1 goes to IDLE and clears claim_valid_o on the next cycle.
REQ-025 SHALL ignore complete_i in IDLE and REQ.
REQ-026 SHALL ignore TCU handshake inputs outside REQ, and in REQ when mcause is not MEXT_INT (exception or other interrupt).
REQ-027 SHALL meet this latency: a source rising at edge n gives pending visible after n; FSM enters REQ and ext_intr_o=1 after edge n+1 (2 cycles).
REQ-028 SHALL re-pend a level source still high after complete, so it is re-requested on the IDLE pass.
REQ-029 SHALL drive ext_intr_o combinationally from the state (=1 only in REQ); all other outputs are registered.

Reset
REQ-030 SHALL, when rst_i=1 at a clock edge, set state=IDLE, pending=0, src_q=0, claim_id_o=0, claim_valid_o=0, ext_intr_o=0, aborting any REQ/SERVICE in progress.
REQ-031 SHALL, when rst_i is asserted during the first cycle a source is high, register no edge event after reset release until a new 0->1 transition.

Verification
REQ-032 SHALL cover: edge source 3 pulses for 1 cycle, enable=0xFF -> pending_o=0x08, ext_intr_o=1 two cycles later, claim_id_o=3; TCU ack (01, 11) -> pending_o=0x00, claim_valid_o=1; complete_i -> IDLE.
REQ-033 SHALL cover: sources 5 and 1 rise in the same cycle -> claim 1 first; after complete, claim 5.
REQ-034 SHALL cover: level source 2 held high through complete -> pending re-set, second REQ with claim_id_o=2.
REQ-035 SHALL cover: in REQ for source 4, irq_enable_i[4] drops -> IDLE, ext_intr_o=0, pending_o[4] still 1.
REQ-036 SHALL cover: in REQ, TCU reports mcause=7 -> stays in REQ; rst_i mid-SERVICE -> all outputs 0 next cycle.
